// File: rtl/led_pattern_sched.sv
// led_pattern_sched: per-bay LED scheduler. Six drive-status requests share one LED by
// fixed priority, with a minimum hold time per pattern and auto-expiry of locate.
module led_pattern_sched #(
    parameter int HOLD_SEC       = 3,
    parameter int LOCATE_TMO_SEC = 60
) (
    input  logic       SYSCLK,
    input  logic       RESET_N,
    input  logic       CLK_1HZ,
    input  logic       CLK_2HZ,
    input  logic       CLK_4HZ,
    input  logic       CLK_4HZ_500MS,
    input  logic       CLK_4HZ_3500MS,
    input  logic       CLK_07S,
    input  logic       FAULT_REQ,
    input  logic       LOCATE_REQ,
    input  logic       REBUILD_REQ,
    input  logic       PFA_REQ,
    input  logic       ACT_REQ,
    input  logic       PRESENT,
    output logic       LED_OUT,
    output logic [2:0] ACTIVE_SRC,
    output logic       LOC_DONE
);
    // LED drive levels, matching `ON / `OFF of status_define
    localparam logic LED_ON  = 1'b1;
    localparam logic LED_OFF = 1'b0;

    localparam logic [2:0] SRC_NONE    = 3'd0;
    localparam logic [2:0] SRC_PRESENT = 3'd1;
    localparam logic [2:0] SRC_ACT     = 3'd2;
    localparam logic [2:0] SRC_PFA     = 3'd3;
    localparam logic [2:0] SRC_REBUILD = 3'd4;
    localparam logic [2:0] SRC_LOCATE  = 3'd5;
    localparam logic [2:0] SRC_FAULT   = 3'd6;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t     state, state_next;
    logic [2:0] src_next;
    logic [2:0] pending;
    logic       cur_req;
    logic       reload;
    logic [3:0] hold_cnt;
    logic       clk_1hz_q;
    logic       sec_tick;
    logic [7:0] loc_cnt;
    logic       loc_exp;
    logic       loc_eff;
    logic       unused;

    // This wave is distributed to every instance but no pattern here uses it
    assign unused  = CLK_4HZ_500MS;
    assign loc_eff = LOCATE_REQ & ~loc_exp;

    always_comb begin
        pending = SRC_NONE;
        if (FAULT_REQ)        pending = SRC_FAULT;
        else if (loc_eff)     pending = SRC_LOCATE;
        else if (REBUILD_REQ) pending = SRC_REBUILD;
        else if (PFA_REQ)     pending = SRC_PFA;
        else if (ACT_REQ)     pending = SRC_ACT;
        else if (PRESENT)     pending = SRC_PRESENT;
    end

    always_comb begin
        cur_req = 1'b0;
        case (ACTIVE_SRC)
            SRC_PRESENT: cur_req = PRESENT;
            SRC_ACT:     cur_req = ACT_REQ;
            SRC_PFA:     cur_req = PFA_REQ;
            SRC_REBUILD: cur_req = REBUILD_REQ;
            SRC_LOCATE:  cur_req = loc_eff;
            SRC_FAULT:   cur_req = FAULT_REQ;
            default:     cur_req = 1'b0;
        endcase
    end

    // Source numbers double as priority, so preemption is a plain magnitude compare
    always_comb begin
        state_next = state;
        src_next   = ACTIVE_SRC;
        reload     = 1'b0;
        case (state)
            IDLE: begin
                if (pending != SRC_NONE) begin
                    state_next = SHOW;
                    src_next   = pending;
                    reload     = 1'b1;
                end
            end
            SHOW: begin
                if (pending > ACTIVE_SRC) begin
                    src_next = pending;
                    reload   = 1'b1;
                end else if (!cur_req && hold_cnt == 4'd0) begin
                    if (pending != SRC_NONE) begin
                        src_next = pending;
                        reload   = 1'b1;
                    end else begin
                        state_next = IDLE;
                        src_next   = SRC_NONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                src_next   = SRC_NONE;
            end
        endcase
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            ACTIVE_SRC <= SRC_NONE;
            hold_cnt   <= 4'd0;
        end else begin
            state      <= state_next;
            ACTIVE_SRC <= src_next;
            if (reload)
                hold_cnt <= 4'(HOLD_SEC);
            else if (sec_tick && hold_cnt != 4'd0)
                hold_cnt <= hold_cnt - 4'd1;
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_1hz_q <= 1'b0;
            sec_tick  <= 1'b0;
        end else begin
            clk_1hz_q <= CLK_1HZ;
            sec_tick  <= CLK_1HZ ^ clk_1hz_q;
        end
    end

    // Expiry latches until locate is dropped, so a fresh locate needs a re-assert
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            loc_cnt  <= 8'd0;
            loc_exp  <= 1'b0;
            LOC_DONE <= 1'b0;
        end else begin
            LOC_DONE <= 1'b0;
            if (!LOCATE_REQ) begin
                loc_cnt <= 8'd0;
                loc_exp <= 1'b0;
            end else if (sec_tick && !loc_exp) begin
                loc_cnt <= loc_cnt + 8'd1;
                if (loc_cnt + 8'd1 == 8'(LOCATE_TMO_SEC)) begin
                    loc_exp  <= 1'b1;
                    LOC_DONE <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            LED_OUT <= LED_OFF;
        end else begin
            case (ACTIVE_SRC)
                SRC_FAULT:   LED_OUT <= CLK_2HZ        ? LED_ON : LED_OFF;
                SRC_LOCATE:  LED_OUT <= CLK_4HZ        ? LED_ON : LED_OFF;
                SRC_REBUILD: LED_OUT <= CLK_1HZ        ? LED_ON : LED_OFF;
                SRC_PFA:     LED_OUT <= CLK_4HZ_3500MS ? LED_ON : LED_OFF;
                SRC_ACT:     LED_OUT <= CLK_07S        ? LED_ON : LED_OFF;
                SRC_PRESENT: LED_OUT <= LED_ON;
                default:     LED_OUT <= LED_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_sched.sv
// tb_led_pattern_sched: directed bench for led_pattern_sched with HOLD_SEC=3 and
// LOCATE_TMO_SEC=5; CLK_1HZ is toggled by hand so second ticks happen on demand.
module tb_led_pattern_sched;
    localparam logic LED_ON  = 1'b1;
    localparam logic LED_OFF = 1'b0;

    logic       sysclk = 1'b0;
    logic       reset_n;
    logic       clk_1hz, clk_2hz, clk_4hz, clk_4hz_500ms, clk_4hz_3500ms, clk_07s;
    logic       fault_req, locate_req, rebuild_req, pfa_req, act_req, present;
    logic       led_out;
    logic [2:0] active_src;
    logic       loc_done;

    int n_checks = 0;
    int n_fail   = 0;

    led_pattern_sched #(.HOLD_SEC(3), .LOCATE_TMO_SEC(5)) dut (
        .SYSCLK(sysclk), .RESET_N(reset_n),
        .CLK_1HZ(clk_1hz), .CLK_2HZ(clk_2hz), .CLK_4HZ(clk_4hz),
        .CLK_4HZ_500MS(clk_4hz_500ms), .CLK_4HZ_3500MS(clk_4hz_3500ms), .CLK_07S(clk_07s),
        .FAULT_REQ(fault_req), .LOCATE_REQ(locate_req), .REBUILD_REQ(rebuild_req),
        .PFA_REQ(pfa_req), .ACT_REQ(act_req), .PRESENT(present),
        .LED_OUT(led_out), .ACTIVE_SRC(active_src), .LOC_DONE(loc_done)
    );

    always #5 sysclk = ~sysclk;

    // Advance n cycles and settle 1 time unit past the rising edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic f, input logic l, input logic r,
                                  input logic p, input logic a, input logic pr);
        fault_req = f; locate_req = l; rebuild_req = r;
        pfa_req = p; act_req = a; present = pr;
    endtask

    // One CLK_1HZ edge; returns after the counters have consumed the tick
    task automatic tick_sec();
        clk_1hz = ~clk_1hz;
        cyc(2);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        clk_1hz = 0; clk_2hz = 0; clk_4hz = 0;
        clk_4hz_500ms = 0; clk_4hz_3500ms = 0; clk_07s = 0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        reset_n = 1'b0;
        clk_1hz = 0; clk_2hz = 0; clk_4hz = 0;
        clk_4hz_500ms = 0; clk_4hz_3500ms = 0; clk_07s = 0;

        $display("[TB] reset with all requests high");
        apply_stimulus(1, 1, 1, 1, 1, 1);
        cyc(3);
        check_output("rst_led", led_out, LED_OFF);
        check_output("rst_src", active_src, 0);
        check_output("rst_locdone", loc_done, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check_output("idle_src", active_src, 0);
            check_output("idle_led", led_out, LED_OFF);
        end

        $display("[TB] preemption present -> fault");
        present = 1'b1;
        cyc(1);
        check_output("pre_src_present", active_src, 1);
        cyc(1);
        check_output("pre_led_present", led_out, LED_ON);
        fault_req = 1'b1;
        cyc(1);
        check_output("pre_src_fault", active_src, 6);
        cyc(1);
        check_output("pre_led_2hz_lo", led_out, LED_OFF);
        clk_2hz = 1'b1;
        cyc(1);
        check_output("pre_led_2hz_hi", led_out, LED_ON);
        clk_2hz = 1'b0;
        cyc(1);
        check_output("pre_led_2hz_lo2", led_out, LED_OFF);

        $display("[TB] hold time on activity");
        do_reset();
        act_req = 1'b1;
        cyc(1);
        check_output("hold_src_act", active_src, 2);
        check_output("hold_cnt_load", dut.hold_cnt, 3);
        clk_07s = 1'b1;
        cyc(1);
        check_output("hold_led_07s_hi", led_out, LED_ON);
        clk_07s = 1'b0;
        cyc(1);
        check_output("hold_led_07s_lo", led_out, LED_OFF);
        tick_sec();
        check_output("hold_cnt_2", dut.hold_cnt, 2);
        act_req = 1'b0;
        present = 1'b1;
        cyc(1);
        check_output("hold_keep_a", active_src, 2);
        tick_sec();
        check_output("hold_cnt_1", dut.hold_cnt, 1);
        check_output("hold_keep_b", active_src, 2);
        tick_sec();
        check_output("hold_cnt_0", dut.hold_cnt, 0);
        check_output("hold_keep_c", active_src, 2);
        cyc(1);
        check_output("hold_to_present", active_src, 1);
        check_output("hold_reload", dut.hold_cnt, 3);
        cyc(1);
        check_output("hold_led_present", led_out, LED_ON);
        present = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_sec();
            check_output("hold_present_kept", active_src, 1);
        end
        cyc(1);
        check_output("hold_to_idle", active_src, 0);
        cyc(1);
        check_output("hold_led_idle", led_out, LED_OFF);

        $display("[TB] tick and reload in the same cycle");
        present = 1'b1;
        cyc(1);
        check_output("coll_src_present", active_src, 1);
        check_output("coll_cnt_load", dut.hold_cnt, 3);
        clk_1hz = ~clk_1hz;
        cyc(1);
        fault_req = 1'b1;
        cyc(1);
        check_output("coll_src_fault", active_src, 6);
        check_output("coll_cnt_reload", dut.hold_cnt, 3);

        $display("[TB] async reset while fault displayed");
        clk_2hz = 1'b1;
        cyc(1);
        check_output("arst_led_before", led_out, LED_ON);
        reset_n = 1'b0;
        clk_1hz = 1'b0;
        #2;
        check_output("arst_led", led_out, LED_OFF);
        check_output("arst_src", active_src, 0);
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        check_output("arst_regrant", active_src, 6);
        cyc(1);
        check_output("arst_led_after", led_out, LED_ON);

        $display("[TB] priority among rebuild / pfa / activity");
        do_reset();
        pfa_req = 1'b1;
        act_req = 1'b1;
        cyc(1);
        check_output("prio_pfa", active_src, 3);
        clk_4hz_3500ms = 1'b1;
        cyc(1);
        check_output("prio_led_pfa", led_out, LED_ON);
        rebuild_req = 1'b1;
        cyc(1);
        check_output("prio_rebuild", active_src, 4);
        cyc(1);
        check_output("prio_led_rebuild", led_out, LED_OFF);

        $display("[TB] locate expiry");
        do_reset();
        locate_req = 1'b1;
        cyc(1);
        check_output("loc_src", active_src, 5);
        for (int i = 1; i <= 4; i++) begin
            tick_sec();
            check_output("loc_src_held", active_src, 5);
            check_output("loc_done_low", loc_done, 0);
        end
        tick_sec();
        check_output("loc_done_pulse", loc_done, 1);
        check_output("loc_src_at_done", active_src, 5);
        cyc(1);
        check_output("loc_done_end", loc_done, 0);
        check_output("loc_src_expired", active_src, 0);
        cyc(3);
        check_output("loc_stays_expired", active_src, 0);
        locate_req = 1'b0;
        cyc(1);
        check_output("loc_dropped", active_src, 0);
        locate_req = 1'b1;
        cyc(1);
        check_output("loc_regrant", active_src, 5);
        clk_4hz = 1'b1;
        cyc(1);
        check_output("loc_led_4hz", led_out, LED_ON);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
